seq_alu_exec: RTL
=================

SEQ_ALU_EXEC -- requirements
Module: seq_alu_exec

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; SHALL be a power of two >= 8.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: flush  input  1  synchronous abort of any in-flight operation.
REQ-005 Port: in_valid  input  1  operation request.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: aluop  input  4  operation code: 0000 AND, 0001 OR, 0010 SUM, 0011 EQUAL, 0100 SHIFT_LEFT, 0101 SHIFT_RIGHT, 0111 SHIFT_RIGHT_A, 1000 XOR, 1010 SUB, 1100 GREATER_EQUAL, 1101 GREATER_EQUAL_U, 1110 SLT, 1111 SLT_U.
REQ-008 Port: op_a  input  WIDTH  first operand.
REQ-009 Port: op_b  input  WIDTH  second operand; low log2(WIDTH) bits are the shift amount for shift codes.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: result  output  WIDTH  operation result.
REQ-013 Port: zero  output  1  high when result == 0; branch-taken indicator.

Function
REQ-014 States SHALL be IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted when in_valid && in_ready; aluop, op_a and the shift amount SHALL be captured on that edge.
REQ-016 On acceptance, non-shift codes SHALL produce result in one cycle: IDLE -> DONE, out_valid high the following cycle.
REQ-017 On acceptance, shift codes with shift amount 0 SHALL go IDLE -> DONE with result = op_a.
REQ-018 On acceptance, shift codes with shift amount N > 0 SHALL go IDLE -> SHIFT, then shift one bit per cycle, down-counting N to zero, then go to DONE; out_valid SHALL assert N+1 cycles after acceptance.
REQ-019 SHIFT_LEFT SHALL fill with 0, SHIFT_RIGHT with 0, SHIFT_RIGHT_A with op_a MSB.
REQ-020 SUM/SUB SHALL be modulo 2^WIDTH, with carry discarded.
REQ-021 EQUAL SHALL give 1 if op_a == op_b, else 0.
REQ-022 GREATER_EQUAL (signed) and GREATER_EQUAL_U (unsigned) SHALL give 1 if op_a >= op_b, else 0.
REQ-023 SLT (signed) and SLT_U (unsigned) SHALL give 1 if op_a < op_b, else 0.
REQ-024 Single-bit results SHALL be zero-extended to WIDTH.
REQ-025 Undefined codes 0110, 1001, 1011 SHALL give result 0 with normal one-cycle latency.
REQ-026 In DONE, out_valid SHALL be 1, and result and zero SHALL be held stable until out_valid && out_ready.
REQ-027 On that handshake edge the block SHALL go DONE -> IDLE; in_ready SHALL rise the next cycle, giving no same-cycle re-accept.
REQ-028 out_valid SHALL be 0 in IDLE and SHIFT.
REQ-029 result during SHIFT is don't-care to consumers.
REQ-030 zero SHALL be combinationally derived from the registered result.
REQ-031 flush high SHALL force IDLE on the next edge from any state, discard any pending result, drop out_valid and block acceptance that cycle; flush SHALL take priority over in_valid and out_ready.
REQ-032 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-033 While rst_n == 0, independent of clk: state = IDLE, result = 0, shift counter = 0, out_valid = 0, in_ready = 1, zero = 1.
REQ-034 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no result SHALL be delivered after release.
REQ-035 Reset deassertion SHALL take effect on the next clk rising edge; the first acceptance is possible at that edge.

Verification
REQ-036 SUB, op_a = 5, op_b = 5, out_ready = 1 -> next cycle out_valid = 1, result = 0, zero = 1; IDLE one cycle later.
REQ-037 SHIFT_RIGHT_A, op_a = 0x80000000, op_b = 4 -> out_valid exactly 5 cycles after acceptance, result = 0xF8000000; in_ready = 0 throughout.
REQ-038 SLT, op_a = 0xFFFFFFFF, op_b = 1 -> result = 1; SLT_U with the same operands -> result = 0; GREATER_EQUAL_U with the same operands -> result = 1.
REQ-039 EQUAL with 7, 7 -> result 1, zero 0. Hold out_ready = 0 for 3 cycles -> result stable and out_valid high; release -> DONE -> IDLE.
REQ-040 SHIFT_LEFT, op_b = 31; flush on 3rd SHIFT cycle -> IDLE next edge, out_valid never asserts. Repeat with rst_n pulsed low mid-SHIFT -> all REQ-033 values immediately.
REQ-041 SHIFT_LEFT with op_b = 0x20 (shift amount 0), op_a = 0x1234 -> one-cycle latency, result = 0x1234.

Source files
------------

// File: rtl/seq_alu_exec.sv
// seq_alu_exec: multi-cycle ALU. Logic and arithmetic codes finish in one cycle.
// Shift codes move one bit per cycle under a down-counter. The result is held
// under a valid/ready handshake.
module seq_alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SUM  = 4'b0010;
  localparam logic [3:0] OP_EQ   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_GE   = 4'b1100;
  localparam logic [3:0] OP_GEU  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shift_res;
  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic             eq_bit;
  logic             lt_s;
  logic             lt_u;

  assign shamt    = op_b[SW-1:0];
  assign is_shift = (aluop == OP_SLL) || (aluop == OP_SRL) || (aluop == OP_SRA);
  assign eq_bit   = (op_a == op_b);
  assign lt_s     = ($signed(op_a) < $signed(op_b));
  assign lt_u     = (op_a < op_b);

  // Single-cycle result for every code; a shift by zero simply passes op_a through.
  always_comb begin
    alu_res = '0;
    case (aluop)
      OP_AND:                 alu_res = op_a & op_b;
      OP_OR:                  alu_res = op_a | op_b;
      OP_SUM:                 alu_res = op_a + op_b;
      OP_EQ:                  alu_res = {{(WIDTH-1){1'b0}}, eq_bit};
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
      OP_XOR:                 alu_res = op_a ^ op_b;
      OP_SUB:                 alu_res = op_a - op_b;
      OP_GE:                  alu_res = {{(WIDTH-1){1'b0}}, ~lt_s};
      OP_GEU:                 alu_res = {{(WIDTH-1){1'b0}}, ~lt_u};
      OP_SLT:                 alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU:                alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      default:                alu_res = '0;
    endcase
  end

  // One-bit step of the captured shift operation applied to the working register.
  always_comb begin
    shift_res = result_q;
    case (op_q)
      OP_SLL:  shift_res = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_res = {1'b0, result_q[WIDTH-1:1]};
      default: shift_res = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
    endcase
  end

  // Next-state logic: flush wins over everything, then accept/shift/handshake.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d = aluop;
            if (is_shift && (shamt != '0)) begin
              result_d = op_a;
              cnt_d    = shamt;
              state_d  = SHIFT;
            end else begin
              result_d = alu_res;
              state_d  = DONE;
            end
          end
        end
        SHIFT: begin
          result_d = shift_res;
          cnt_d    = cnt_q - SW'(1);
          if (cnt_q == SW'(1)) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = ~|result_q;

endmodule
